// File: rtl/mem_align_ctrl.sv
// mem_align_ctrl: MEM-stage load/store alignment front end for data_mem.
// Aligned accesses pass through in the same cycle. Misaligned word and
// halfword accesses are split into byte beats, with the pipeline stalled.
// Build option MISALIGN_TRAP_EN rejects misaligned accesses with a trap
// pulse on misalign_o instead of splitting them.
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   req_i, we_i              access valid, 1 = store
//   width_src_i, addr_i      access width/sign code, byte address
//   wdata_i                  store data (little-endian)
//   mem_we_o, mem_width_src_o, mem_addr_o, mem_wd_o  to data_mem
//   mem_rd_i                 data_mem read data (combinational)
//   rdata_o                  load result to pipeline
//   stall_o                  hold pipeline while a split runs
//   misalign_o               trap pulse (trap build only, else 0)

`ifndef WIDTH_32
`define WIDTH_32  3'd0
`define WIDTH_16S 3'd1
`define WIDTH_16U 3'd2
`define WIDTH_8S  3'd3
`define WIDTH_8U  3'd4
`endif

module mem_align_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            width_src_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  mem_we_o,
  output logic [2:0]            mem_width_src_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wd_o,
  input  logic [31:0]           mem_rd_i,
  output logic [31:0]           rdata_o,
  output logic                  stall_o,
  output logic                  misalign_o
);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t                state_q, state_d;
  logic [1:0]            beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  we_q, we_d;
  logic [2:0]            width_q, width_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [23:0]           buf_q, buf_d;

  logic       is_half;
  logic       mis;
  logic [1:0] last_beat;
  logic [7:0] wbyte;
  logic [7:0] rbyte;
  logic       mwe;
`ifdef MISALIGN_TRAP_EN
  logic       trap;
`endif

  assign rbyte = mem_rd_i[7:0];

  always_comb begin
    is_half = (width_src_i == `WIDTH_16S) ||
              (width_src_i == `WIDTH_16U);
    mis = 1'b0;
    if (req_i) begin
      if (width_src_i == `WIDTH_32)
        mis = (addr_i[1:0] != 2'b00);
      else if (is_half)
        mis = addr_i[0];
    end
  end

  assign last_beat = (width_q == `WIDTH_32) ? 2'd3 : 2'd1;

  always_comb begin
    case (beat_q)
      2'd0:    wbyte = wdata_q[7:0];
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      default: wbyte = wdata_q[31:24];
    endcase
  end

  // Output decode
  always_comb begin
    mwe             = 1'b0;
    mem_width_src_o = width_src_i;
    mem_addr_o      = addr_i;
    mem_wd_o        = wdata_i;
    rdata_o         = mem_rd_i;
    stall_o         = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap            = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          mwe = we_i;
          if (mis) begin
`ifdef MISALIGN_TRAP_EN
            mwe     = 1'b0;
            trap    = 1'b1;
            rdata_o = '0;
`else
            mem_width_src_o = `WIDTH_8S;
            mem_wd_o        = {24'b0, wdata_i[7:0]};
            stall_o         = 1'b1;
`endif
          end
        end
      end
      SPLIT: begin
        mwe             = we_q;
        mem_addr_o      = base_q + ADDR_WIDTH'(beat_q);
        mem_width_src_o = `WIDTH_8S;
        mem_wd_o        = {24'b0, wbyte};
        if (beat_q == last_beat) begin
          if (!we_q) begin
            if (width_q == `WIDTH_32)
              rdata_o = {rbyte, buf_q};
            else if (width_q == `WIDTH_16S)
              rdata_o = {{16{rbyte[7]}}, rbyte, buf_q[7:0]};
            else
              rdata_o = {16'b0, rbyte, buf_q[7:0]};
          end
        end else begin
          stall_o = 1'b1;
        end
      end
    endcase
  end

  // No writes reach memory during a reset cycle
  assign mem_we_o = mwe & ~reset_i;

`ifdef MISALIGN_TRAP_EN
  assign misalign_o = trap;
`else
  assign misalign_o = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    base_d  = base_q;
    we_d    = we_q;
    width_d = width_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: begin
`ifndef MISALIGN_TRAP_EN
        if (mis) begin
          state_d      = SPLIT;
          beat_d       = 2'd1;
          base_d       = addr_i;
          we_d         = we_i;
          width_d      = width_src_i;
          wdata_d      = wdata_i;
          buf_d[7:0]   = rbyte;
        end
`endif
      end
      SPLIT: begin
        if (beat_q == last_beat) begin
          state_d = IDLE;
          beat_d  = 2'd0;
        end else begin
          case (beat_q)
            2'd1:    buf_d[15:8]  = rbyte;
            2'd2:    buf_d[23:16] = rbyte;
            default: buf_d        = buf_q;
          endcase
          beat_d = beat_q + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      width_q <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      we_q    <= we_d;
      width_q <= width_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: doc/mem_align_ctrl.md
Name: mem_align_ctrl

Overview:
- Sits between the MEM-stage load/store signals and data_mem.
- Aligned accesses pass straight through in the same cycle.
- Misaligned word/halfword accesses become a sequence of byte accesses to data_mem. The pipeline is stalled while the sequence runs, and load bytes are reassembled and extended.
- Optional build-time trap mode rejects misaligned accesses instead of splitting them.

Parameters:
- ADDR_WIDTH, 32, width of byte address; address arithmetic wraps modulo 2^ADDR_WIDTH.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- req_i  in  1  MEM-stage access valid.
- we_i  in  1  1 = store, 0 = load.
- width_src_i  in  3  access width/sign, codebase encoding (`WIDTH_32, `WIDTH_16S, `WIDTH_16U, `WIDTH_8S, `WIDTH_8U).
- addr_i  in  ADDR_WIDTH  byte address.
- wdata_i  in  32  store data, little-endian.
- mem_we_o  out  1  to data_mem WE.
- mem_width_src_o  out  3  to data_mem width_src.
- mem_addr_o  out  ADDR_WIDTH  to data_mem A.
- mem_wd_o  out  32  to data_mem WD.
- mem_rd_i  in  32  from data_mem RD; combinational read.
- rdata_o  out  32  load result to pipeline.
- stall_o  out  1  hold pipeline; inputs must stay stable while high.
- misalign_o  out  1  misaligned-access trap pulse; tied 0 unless MISALIGN_TRAP_EN.

Behaviour:
- Misaligned definition:
  - word: addr_i[1:0] != 0.
  - halfword: addr_i[0] = 1.
  - Bytes are never misaligned.
  - N = beats: 4 for word, 2 for halfword.
- FSM states: IDLE, SPLIT.
  - Registers: state, beat_q[1:0], base address, we, width, wdata, byte buffer (3 x 8 bits).
  - Reset: state IDLE, beat_q 0, all registers 0.
- IDLE, req_i=0:
  - mem_we_o=0, stall_o=0, misalign_o=0.
  - mem_addr_o=addr_i, mem_width_src_o=width_src_i, mem_wd_o=wdata_i, rdata_o=mem_rd_i.
- IDLE, aligned req:
  - Pure pass-through: mem_we_o=we_i, other mem_* = inputs, rdata_o=mem_rd_i.
  - stall_o=0; zero added latency.
- IDLE, misaligned req, beat 0 issued in the same cycle:
  - mem_addr_o=addr_i, mem_width_src_o=`WIDTH_8S, mem_we_o=we_i, mem_wd_o={24'b0, wdata_i[7:0]}.
  - stall_o=1.
  - On the clock edge: latch the request, store mem_rd_i[7:0] into buffer[0], set beat_q=1, go to SPLIT.
- SPLIT, beat k (k = beat_q):
  - mem_addr_o = base + k (wrapping); width `WIDTH_8S; mem_wd_o = {24'b0, wdata byte k}; mem_we_o = latched we.
  - If k < N-1: stall_o=1; capture mem_rd_i[7:0] into buffer[k]; beat_q++.
  - If k = N-1: stall_o=0 and rdata_o valid in this cycle. Next state IDLE, beat_q 0.
- Load assembly on the last beat, little-endian:
  - word = {mem_rd_i[7:0], buf[2], buf[1], buf[0]}.
  - halfword = {mem_rd_i[7:0], buf[0]}, sign-extended for 16S, zero-extended for 16U.
- Latency: misaligned access takes N cycles and holds stall_o high for N-1 cycles.
- req_i and all inputs are ignored while in SPLIT; latched values are used.
- Back-to-back accesses: a new req in the cycle after the final beat is handled in IDLE normally.
- Reset mid-SPLIT: IDLE next cycle, stall_o=0. Bytes already written stay written (no rollback). Partial load is discarded.
- Store rdata_o: don't-care, but driven from mem_rd_i (no X).

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - A misaligned req in IDLE issues no memory access (mem_we_o=0).
  - misalign_o=1 for that cycle only, stall_o=0, rdata_o=0.
  - FSM never enters SPLIT.
- Not defined: splitting behaviour as above, misalign_o constant 0.

Test Plan:
- Aligned store `WIDTH_32, addr 0x10, wdata 0xDEADBEEF -> same cycle: mem_we_o=1, mem_addr_o=0x10, stall_o=0. Aligned load at 0x10 -> rdata_o=0xDEADBEEF.
- Misaligned store `WIDTH_32, addr 0x21, wdata 0x44332211 -> 4 beats at 0x21..0x24, byte width, WD low bytes 11,22,33,44; stall_o=1,1,1,0. Byte loads at 0x21..0x24 return 0x11,0x22,0x33,0x44.
- Misaligned load `WIDTH_32 at 0x21 after previous test -> rdata_o=0x44332211 in 4th cycle, stall_o high first 3 cycles, mem_we_o=0 throughout.
- Bytes 0x31=0x80, 0x32=0xFF:
  - `WIDTH_16S load at 0x31 -> 0xFFFFFF80 after 2 cycles.
  - `WIDTH_16U load at 0x31 -> 0x0000FF80.
  - Store `WIDTH_16S 0x1234 at 0x33 -> 0x33=0x34, 0x34=0x12.
- Misaligned word store at 0x41 of 0xAABBCCDD, reset_i asserted during beat 2 -> next cycle IDLE, stall_o=0. Memory has 0x41=0xDD, 0x42=0xCC; 0x43/0x44 unchanged.
- MISALIGN_TRAP_EN build: `WIDTH_32 load at 0x02 -> misalign_o=1 one cycle, mem_we_o=0, stall_o=0. Aligned access on the next cycle passes through normally.
